// File: rtl/music_select.sv
// -----------------------------------------------------------------------------
// music_select
//   Song index selector for the playback path. Two raw active-low push keys
//   (next / prev) are synchronised, debounced and turned into single press
//   events; together with the player's end-of-song pulse they step a 2-bit
//   song index with wrap-around. A one-cycle strobe marks every real change
//   of the index so downstream logic can clear its note counters.
//
// Parameters
//   DEB_CNT    stable-level cycles a synchronised key must hold (min 2)
//   NUM_SONGS  number of selectable songs, 1..4
//   AUTO_NEXT  1 = song_done advances the index like a next press
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   key_next   raw next key, active-low, asynchronous
//   key_prev   raw prev key, active-low, asynchronous
//   song_done  one-cycle end-of-song pulse, synchronous to clk
//   music_reg  current song index
//   sel_pulse  high for one cycle after each edge that changed music_reg
// -----------------------------------------------------------------------------
module music_select #(
   parameter int DEB_CNT   = 1000000,
   parameter int NUM_SONGS = 4,
   parameter int AUTO_NEXT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_next,
   input  logic       key_prev,
   input  logic       song_done,
   output logic [1:0] music_reg,
   output logic       sel_pulse
);

   localparam int               CNT_W   = $clog2(DEB_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);
   localparam logic [1:0]       LAST    = 2'(NUM_SONGS - 1);

   // bit 0 = next key, bit 1 = prev key
   logic [1:0] key_raw;
   logic [1:0] press_evt;

   assign key_raw = {key_prev, key_next};

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic             key_p0;
      logic             key_p1;
      logic             stable;
      logic [CNT_W-1:0] cnt;

      // sync stage: two flops, key_p1 is the synchronised level
      always_ff @(posedge clk) begin
         if (rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
         end else begin
            key_p0 <= key_raw[k];
            key_p1 <= key_p0;
         end
      end

      // debounce stage: accept a new level only after it held DEB_CNT cycles
      always_ff @(posedge clk) begin
         if (rst) begin
            stable <= 1'b1;
            cnt    <= '0;
         end else if (key_p1 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= key_p1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      // press = the edge on which stable falls 1->0; releases give nothing
      assign press_evt[k] = stable & ~key_p1 & (cnt == CNT_MAX);
   end

   logic       step_up;
   logic       step_dn;
   logic [1:0] music_nxt;

   assign step_up = press_evt[0] | ((AUTO_NEXT != 0) & song_done);
   assign step_dn = press_evt[1];

   always_comb begin
      music_nxt = music_reg;
      if (step_up && !step_dn) begin
         music_nxt = (music_reg == LAST) ? 2'd0 : music_reg + 2'd1;
      end else if (step_dn && !step_up) begin
         music_nxt = (music_reg == 2'd0) ? LAST : music_reg - 2'd1;
      end
   end

   // index stage: register the index and flag real changes
   always_ff @(posedge clk) begin
      if (rst) begin
         music_reg <= 2'd0;
         sel_pulse <= 1'b0;
      end else begin
         music_reg <= music_nxt;
         sel_pulse <= (music_nxt != music_reg);
      end
   end

endmodule

// File: tb/tb_music_select.sv
module tb_music_select;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_next;
   logic       key_prev;
   logic       song_done;
   logic [1:0] music4, music3, music1;
   logic       sel4, sel3, sel1;

   int total = 0;
   int bad   = 0;
   int p4, p3, p1;

   always #5 clk = ~clk;

   // 4 songs, auto-next on
   music_select #(.DEB_CNT(4), .NUM_SONGS(4), .AUTO_NEXT(1)) u_dut4 (
      .clk(clk), .rst(rst), .key_next(key_next), .key_prev(key_prev),
      .song_done(song_done), .music_reg(music4), .sel_pulse(sel4));

   // 3 songs, auto-next off
   music_select #(.DEB_CNT(4), .NUM_SONGS(3), .AUTO_NEXT(0)) u_dut3 (
      .clk(clk), .rst(rst), .key_next(key_next), .key_prev(key_prev),
      .song_done(song_done), .music_reg(music3), .sel_pulse(sel3));

   // single song: index must never move
   music_select #(.DEB_CNT(4), .NUM_SONGS(1), .AUTO_NEXT(1)) u_dut1 (
      .clk(clk), .rst(rst), .key_next(key_next), .key_prev(key_prev),
      .song_done(song_done), .music_reg(music1), .sel_pulse(sel1));

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // advance n edges, sample 1 time unit after each edge, count strobes
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         p4 += int'(sel4);
         p3 += int'(sel3);
         p1 += int'(sel1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   // clean press: low long enough to debounce, then a debounced release
   task automatic press(input bit prev_key);
      if (prev_key) key_prev = 1'b0; else key_next = 1'b0;
      run(8);
      key_prev = 1'b1;
      key_next = 1'b1;
      run(8);
   endtask

   int exp4 [4] = '{1, 2, 3, 0};
   int exp3 [4] = '{1, 2, 0, 1};

   initial begin
      rst       = 1'b1;
      key_next  = 1'b1;
      key_prev  = 1'b1;
      song_done = 1'b0;
      p1 = 0;
      @(posedge clk);
      #1;
      do_reset();
      chk("reset_music4", int'(music4), 0);
      chk("reset_sel4", int'(sel4), 0);
      chk("reset_music3", int'(music3), 0);

      // idle keys
      p4 = 0; p3 = 0;
      run(50);
      chk("idle_music4", int'(music4), 0);
      chk("idle_pulses4", p4, 0);

      // held next press: first sampling edge is edge 1, update at edge 6
      key_next = 1'b0;
      p4 = 0;
      run(5);
      chk("latency_pre5", int'(music4), 0);
      run(1);
      chk("latency_edge6_music", int'(music4), 1);
      chk("latency_edge6_sel", int'(sel4), 1);
      run(1);
      chk("latency_sel_drop", int'(sel4), 0);
      run(13);
      key_next = 1'b1;
      run(15);
      chk("hold_release_music4", int'(music4), 1);
      chk("hold_release_pulses4", p4, 1);
      chk("hold_release_music3", int'(music3), 1);

      // glitches of 1..3 cycles, repeated
      p4 = 0; p3 = 0;
      for (int r = 0; r < 2; r++) begin
         for (int len = 1; len <= 3; len++) begin
            key_next = 1'b0;
            run(len);
            key_next = 1'b1;
            run(6);
         end
      end
      chk("glitch_music4", int'(music4), 1);
      chk("glitch_pulses4", p4, 0);
      chk("glitch_pulses3", p3, 0);

      // four clean next presses from 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         p4 = 0; p3 = 0;
         press(1'b0);
         chk($sformatf("next%0d_music4", i), int'(music4), exp4[i]);
         chk($sformatf("next%0d_music3", i), int'(music3), exp3[i]);
         chk($sformatf("next%0d_pulse4", i), p4, 1);
      end

      // prev from 0 wraps to last song
      do_reset();
      p4 = 0; p3 = 0;
      press(1'b1);
      chk("prev_wrap_music4", int'(music4), 3);
      chk("prev_wrap_music3", int'(music3), 2);
      chk("prev_wrap_pulses3", p3, 1);

      // song_done at index 2
      do_reset();
      press(1'b0);
      press(1'b0);
      chk("pre_done_music4", int'(music4), 2);
      chk("pre_done_music3", int'(music3), 2);
      song_done = 1'b1;
      run(1);
      song_done = 1'b0;
      chk("done_music4", int'(music4), 3);
      chk("done_sel4", int'(sel4), 1);
      chk("done_off_music3", int'(music3), 2);
      chk("done_off_sel3", int'(sel3), 0);
      run(1);
      chk("done_sel4_drop", int'(sel4), 0);

      // back-to-back song_done pulses
      song_done = 1'b1;
      run(1);
      chk("b2b_a_music4", int'(music4), 0);
      chk("b2b_a_sel4", int'(sel4), 1);
      run(1);
      song_done = 1'b0;
      chk("b2b_b_music4", int'(music4), 1);
      chk("b2b_b_sel4", int'(sel4), 1);
      run(1);
      chk("b2b_music3", int'(music3), 2);

      // song_done coincident with prev event (fires at edge 6)
      key_prev = 1'b0;
      run(5);
      song_done = 1'b1;
      run(1);
      song_done = 1'b0;
      chk("coinc_music4", int'(music4), 1);
      chk("coinc_sel4", int'(sel4), 0);
      chk("coinc_music3", int'(music3), 1);
      chk("coinc_sel3", int'(sel3), 1);
      key_prev = 1'b1;
      run(8);

      // reset mid-debounce (counter=2 after edge 4), key kept low
      do_reset();
      key_next = 1'b0;
      run(4);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      chk("mid_rst_music4", int'(music4), 0);
      chk("mid_rst_sel4", int'(sel4), 0);
      p4 = 0;
      run(5);
      chk("mid_rst_restart_pre", int'(music4), 0);
      chk("mid_rst_restart_pulses", p4, 0);
      run(1);
      chk("mid_rst_restart_music4", int'(music4), 1);
      chk("mid_rst_restart_sel4", int'(sel4), 1);
      key_next = 1'b1;
      run(8);

      chk("single_song_music", int'(music1), 0);
      chk("single_song_pulses", p1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
